// File: rtl/frame_readout_sequencer.sv
// ---------------------------------------------------------------------------
// frame_readout_sequencer
//
// Purpose: arms an upstream frame store, waits for it to capture a frame,
// then streams the frame out as 32-bit words on an AXI-Stream-style channel.
// A run covers num_frames frames, or runs until stopped when num_frames is 0.
//
// Ports:
//   axi_clk, axi_resetn      clock, asynchronous active-low reset
//   start, stop              single-cycle command pulses
//   num_frames               frames per run (0 = continuous)
//   timeout_cycles           trigger/capture wait limit (0 = no limit)
//   fs_trigger               one-cycle arm pulse to the frame store
//   fs_status                frame store status (bit0 = triggered)
//   fs_frame_read            current frame store chunk
//   fs_frame_read_rdStrobe   advances the frame store chunk pointer
//   m_tdata/m_tvalid/m_tready/m_tuser/m_tlast   output word channel
//   busy, done, timeout_err, frames_captured    run status
// ---------------------------------------------------------------------------
module frame_readout_sequencer #(
  parameter int FRAME_WIDTH = 256,
  parameter int TIMEOUT_W   = 24
) (
  input  logic                 axi_clk,
  input  logic                 axi_resetn,
  input  logic                 start,
  input  logic                 stop,
  input  logic [15:0]          num_frames,
  input  logic [TIMEOUT_W-1:0] timeout_cycles,
  output logic                 fs_trigger,
  input  logic [31:0]          fs_status,
  input  logic [31:0]          fs_frame_read,
  output logic                 fs_frame_read_rdStrobe,
  output logic [31:0]          m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic                 m_tuser,
  output logic                 m_tlast,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [15:0]          frames_captured
);

  localparam int NUM_CHUNKS = (FRAME_WIDTH + 31) / 32;
  localparam int CW         = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NUM_CHUNKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_TRIG,
    S_WAIT_CAP,
    S_READ,
    S_DRAIN
  } state_t;

  state_t               r_state;
  logic [TIMEOUT_W-1:0] r_to_cnt;
  logic [CW-1:0]        r_chunk;
  logic                 r_stop_req;
  logic [31:0]          r_tdata;
  logic                 r_tvalid;
  logic                 r_tuser;
  logic                 r_tlast;
  logic                 r_done;
  logic                 r_timeout_err;
  logic [15:0]          r_frames;

  logic                 w_load;
  logic                 w_accept;
  logic                 w_timeout;
  logic [15:0]          w_frames_inc;
  logic                 w_last_frame;
  logic                 w_stop_any;
  logic                 w_unused_status;

  // Only the "triggered" bit steers the sequence; capture-complete and the
  // reserved bits are not needed because the falling edge of bit0 already
  // marks a stable frame.
  assign w_unused_status = ^fs_status[31:1];

  // Load the output register when it is empty or being drained this cycle.
  // Leaving READ right after the last load bounds the loads per frame.
  assign w_load       = (r_state == S_READ) && (!r_tvalid || m_tready);
  assign w_accept     = r_tvalid && m_tready;
  assign w_timeout    = (timeout_cycles != '0) && (r_to_cnt == timeout_cycles);
  assign w_frames_inc = r_frames + 16'd1;
  assign w_last_frame = (num_frames != 16'd0) && (w_frames_inc == num_frames);
  // A stop arriving on the very cycle the tlast word is accepted still counts.
  assign w_stop_any   = stop || r_stop_req;

  // The strobe must coincide with the load so the frame store pointer
  // advances on the same edge that captures the current chunk.
  assign fs_frame_read_rdStrobe = w_load;
  // ARM always lasts exactly one cycle, so decoding it gives a single pulse.
  assign fs_trigger      = (r_state == S_ARM);
  assign busy            = (r_state != S_IDLE);
  assign m_tdata         = r_tdata;
  assign m_tvalid        = r_tvalid;
  assign m_tuser         = r_tuser;
  assign m_tlast         = r_tlast;
  assign done            = r_done;
  assign timeout_err     = r_timeout_err;
  assign frames_captured = r_frames;

  always_ff @(posedge axi_clk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      r_state       <= S_IDLE;
      r_to_cnt      <= '0;
      r_chunk       <= '0;
      r_stop_req    <= 1'b0;
      r_tdata       <= '0;
      r_tvalid      <= 1'b0;
      r_tuser       <= 1'b0;
      r_tlast       <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_frames      <= '0;
    end else begin
      r_done <= 1'b0;

      // Output word register, shared by READ and DRAIN.
      if (w_load) begin
        r_tdata  <= fs_frame_read;
        r_tvalid <= 1'b1;
        r_tuser  <= (r_chunk == '0);
        r_tlast  <= (r_chunk == LAST_CHUNK);
        r_chunk  <= r_chunk + CW'(1);
      end else if (w_accept) begin
        r_tvalid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_frames      <= '0;
            r_timeout_err <= 1'b0;
            r_stop_req    <= 1'b0;
            r_state       <= S_ARM;
          end
        end

        S_ARM: begin
          r_to_cnt <= '0;
          r_state  <= stop ? S_IDLE : S_WAIT_TRIG;
        end

        S_WAIT_TRIG: begin
          if (stop) begin
            r_state <= S_IDLE;
          end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else if (fs_status[0]) begin
            r_to_cnt <= '0;
            r_state  <= S_WAIT_CAP;
          end else begin
            r_to_cnt <= r_to_cnt + TIMEOUT_W'(1);
          end
        end

        S_WAIT_CAP: begin
          if (stop) begin
            r_state <= S_IDLE;
          end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
          end else if (!fs_status[0]) begin
            r_to_cnt <= '0;
            r_chunk  <= '0;
            r_state  <= S_READ;
          end else begin
            r_to_cnt <= r_to_cnt + TIMEOUT_W'(1);
          end
        end

        S_READ: begin
          if (stop) begin
            r_stop_req <= 1'b1;
          end
          if (w_load && (r_chunk == LAST_CHUNK)) begin
            r_state <= S_DRAIN;
          end
        end

        S_DRAIN: begin
          if (stop) begin
            r_stop_req <= 1'b1;
          end
          // The only word left in flight here is the tlast word.
          if (w_accept && r_tlast) begin
            r_frames <= w_frames_inc;
            if (w_stop_any || w_last_frame) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_ARM;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_readout_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_readout_sequencer
//
// Directed bench. Instance A uses a 256-bit frame (8 words), instance B an
// 80-bit frame (3 words). A small frame store model per instance serves
// chunks from a pointer that the trigger zeroes and the strobe advances; a
// shared status model raises fs_status[0] a few cycles after a trigger.
// ---------------------------------------------------------------------------
module tb_frame_readout_sequencer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        start_a, start_b, stop;
  logic [15:0] num_frames;
  logic [23:0] timeout_cycles;
  logic [31:0] fs_status;
  logic        m_tready;
  logic        fs_auto;

  logic        trig_a, strb_a, tvalid_a, tuser_a, tlast_a, busy_a, done_a, terr_a;
  logic [31:0] rd_a, tdata_a;
  logic [15:0] fc_a;
  logic        trig_b, strb_b, tvalid_b, tuser_b, tlast_b, busy_b, done_b, terr_b;
  logic [31:0] rd_b, tdata_b;
  logic [15:0] fc_b;

  frame_readout_sequencer #(.FRAME_WIDTH(256), .TIMEOUT_W(24)) u_dut_a (
    .axi_clk(clk), .axi_resetn(rstn), .start(start_a), .stop(stop),
    .num_frames(num_frames), .timeout_cycles(timeout_cycles),
    .fs_trigger(trig_a), .fs_status(fs_status), .fs_frame_read(rd_a),
    .fs_frame_read_rdStrobe(strb_a), .m_tdata(tdata_a), .m_tvalid(tvalid_a),
    .m_tready(m_tready), .m_tuser(tuser_a), .m_tlast(tlast_a), .busy(busy_a),
    .done(done_a), .timeout_err(terr_a), .frames_captured(fc_a)
  );

  frame_readout_sequencer #(.FRAME_WIDTH(80), .TIMEOUT_W(24)) u_dut_b (
    .axi_clk(clk), .axi_resetn(rstn), .start(start_b), .stop(stop),
    .num_frames(num_frames), .timeout_cycles(timeout_cycles),
    .fs_trigger(trig_b), .fs_status(fs_status), .fs_frame_read(rd_b),
    .fs_frame_read_rdStrobe(strb_b), .m_tdata(tdata_b), .m_tvalid(tvalid_b),
    .m_tready(m_tready), .m_tuser(tuser_b), .m_tlast(tlast_b), .busy(busy_b),
    .done(done_b), .timeout_err(terr_b), .frames_captured(fc_b)
  );

  // ---------------- frame store models ----------------
  logic [7:0]  ptr_a = 8'd0;
  logic [7:0]  ptr_b = 8'd0;
  logic [3:0]  st_cnt = 4'd0;

  always @(posedge clk) begin
    if (trig_a) ptr_a <= 8'd0;
    else if (strb_a) ptr_a <= ptr_a + 8'd1;
    if (trig_b) ptr_b <= 8'd0;
    else if (strb_b) ptr_b <= ptr_b + 8'd1;
    if (trig_a || trig_b) st_cnt <= 4'd1;
    else if (st_cnt != 4'd0 && st_cnt != 4'd6) st_cnt <= st_cnt + 4'd1;
  end

  assign rd_a = {16'hC0DE, 8'h00, ptr_a};

  // 80-bit frame 0x1234_89ABCDEF_01234567, upper chunk zero-extended.
  always_comb begin
    case (ptr_b)
      8'd0:    rd_b = 32'h0123_4567;
      8'd1:    rd_b = 32'h89AB_CDEF;
      8'd2:    rd_b = 32'h0000_1234;
      default: rd_b = 32'h0000_0000;
    endcase
  end

  assign fs_status = {30'd0, fs_auto && (st_cnt == 4'd6),
                      fs_auto && (st_cnt >= 4'd3) && (st_cnt <= 4'd5)};

  // ---------------- monitors ----------------
  typedef struct packed {
    logic        tuser;
    logic        tlast;
    logic [31:0] data;
  } beat_t;

  beat_t acc_a[$];
  beat_t acc_b[$];
  int n_strb_a = 0, n_strb_b = 0, n_trig_a = 0, n_trig_b = 0;
  int n_done_a = 0, n_done_b = 0;

  always @(posedge clk) begin
    if (tvalid_a && m_tready) acc_a.push_back(beat_t'({tuser_a, tlast_a, tdata_a}));
    if (tvalid_b && m_tready) acc_b.push_back(beat_t'({tuser_b, tlast_b, tdata_b}));
    if (strb_a) n_strb_a <= n_strb_a + 1;
    if (strb_b) n_strb_b <= n_strb_b + 1;
    if (trig_a) n_trig_a <= n_trig_a + 1;
    if (trig_b) n_trig_b <= n_trig_b + 1;
    if (done_a) n_done_a <= n_done_a + 1;
    if (done_b) n_done_b <= n_done_b + 1;
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
    $display("check %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1; tick(); start_a = 1'b0;
  endtask

  task automatic pulse_start_b();
    start_b = 1'b1; tick(); start_b = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic check_frame_a(input string tag, input int base);
    for (int k = 0; k < 8; k++) begin
      if (base + k < acc_a.size()) begin
        check32($sformatf("%s_w%0d_data", tag, k), acc_a[base+k].data,
                {16'hC0DE, 8'h00, 8'(k)});
        check1($sformatf("%s_w%0d_tuser", tag, k), acc_a[base+k].tuser, k == 0);
        check1($sformatf("%s_w%0d_tlast", tag, k), acc_a[base+k].tlast, k == 7);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  int b_trig, b_strb, b_done, b_acc, busy_cycles, n_hold;
  logic prev_valid, prev_ready, prev_user, prev_last, tog;
  logic [31:0] prev_data;

  initial begin
    rstn = 1'b1; start_a = 1'b0; start_b = 1'b0; stop = 1'b0;
    num_frames = 16'd1; timeout_cycles = 24'd0; m_tready = 1'b1; fs_auto = 1'b1;

    // Reset values
    tick(); rstn = 1'b0;
    repeat (3) tick();
    check1("rst_busy", busy_a, 1'b0);
    check1("rst_tvalid", tvalid_a, 1'b0);
    check1("rst_tuser", tuser_a, 1'b0);
    check1("rst_tlast", tlast_a, 1'b0);
    check1("rst_done", done_a, 1'b0);
    check1("rst_terr", terr_a, 1'b0);
    check1("rst_trig", trig_a, 1'b0);
    check1("rst_strobe", strb_a, 1'b0);
    check32("rst_tdata", tdata_a, 32'd0);
    check32("rst_fc", 32'(fc_a), 32'd0);
    rstn = 1'b1;
    repeat (3) tick();
    check1("idle_after_rst", busy_a, 1'b0);
    pulse_stop();
    tick();
    check1("stop_in_idle", busy_a, 1'b0);

    // Single frame, 256-bit, m_tready = 1
    b_trig = n_trig_a; b_strb = n_strb_a; b_done = n_done_a; b_acc = acc_a.size();
    pulse_start_a();
    check1("t1_busy", busy_a, 1'b1);
    check1("t1_trig_on", trig_a, 1'b1);
    tick();
    check1("t1_trig_off", trig_a, 1'b0);
    for (int i = 0; i < 200; i++) begin
      if (done_a) break;
      tick();
    end
    check1("t1_done_seen", done_a, 1'b1);
    tick();
    check1("t1_done_pulse", done_a, 1'b0);
    check1("t1_busy_end", busy_a, 1'b0);
    check32("t1_fc", 32'(fc_a), 32'd1);
    check32("t1_trigs", n_trig_a - b_trig, 32'd1);
    check32("t1_strobes", n_strb_a - b_strb, 32'd8);
    check32("t1_dones", n_done_a - b_done, 32'd1);
    check32("t1_words", acc_a.size() - b_acc, 32'd8);
    check_frame_a("t1", b_acc);

    // Timeout: status never rises, limit 10 -> busy for 2 + 10 cycles
    fs_auto = 1'b0; timeout_cycles = 24'd10;
    b_trig = n_trig_a; b_strb = n_strb_a; b_done = n_done_a;
    pulse_start_a();
    busy_cycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (!busy_a) break;
      busy_cycles++;
      tick();
    end
    check32("t2_busy_cycles", busy_cycles, 32'd12);
    check1("t2_terr", terr_a, 1'b1);
    check1("t2_busy", busy_a, 1'b0);
    repeat (3) tick();
    check1("t2_terr_sticky", terr_a, 1'b1);
    check32("t2_dones", n_done_a - b_done, 32'd0);
    check32("t2_strobes", n_strb_a - b_strb, 32'd0);
    check32("t2_trigs", n_trig_a - b_trig, 32'd1);

    // Stop while waiting for trigger
    timeout_cycles = 24'd0; b_done = n_done_a;
    pulse_start_a();
    repeat (4) tick();
    check1("t3_terr_cleared", terr_a, 1'b0);
    check1("t3_busy_wait", busy_a, 1'b1);
    pulse_stop();
    check1("t3_stopped", busy_a, 1'b0);
    tick();
    check32("t3_dones", n_done_a - b_done, 32'd0);

    // Backpressure, 80-bit frame, m_tready toggling
    fs_auto = 1'b1; num_frames = 16'd1;
    b_strb = n_strb_b; b_done = n_done_b; b_acc = acc_b.size();
    pulse_start_b();
    prev_valid = 1'b0; prev_ready = 1'b1; tog = 1'b1; n_hold = 0;
    prev_data = 32'd0; prev_user = 1'b0; prev_last = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (prev_valid && !prev_ready) begin
        n_hold++;
        check32($sformatf("t4_hold%0d_data", n_hold), tdata_b, prev_data);
        check1($sformatf("t4_hold%0d_tuser", n_hold), tuser_b, prev_user);
        check1($sformatf("t4_hold%0d_tlast", n_hold), tlast_b, prev_last);
      end
      if (done_b) break;
      prev_valid = tvalid_b; prev_data = tdata_b;
      prev_user = tuser_b; prev_last = tlast_b;
      prev_ready = tog; m_tready = tog; tog = ~tog;
      tick();
    end
    check1("t4_done_seen", done_b, 1'b1);
    m_tready = 1'b1;
    tick();
    check1("t4_stalls_seen", n_hold > 0, 1'b1);
    check32("t4_words", acc_b.size() - b_acc, 32'd3);
    check32("t4_strobes", n_strb_b - b_strb, 32'd3);
    check32("t4_dones", n_done_b - b_done, 32'd1);
    check32("t4_fc", 32'(fc_b), 32'd1);
    check1("t4_busy", busy_b, 1'b0);
    if (acc_b.size() - b_acc >= 3) begin
      check32("t4_w0_data", acc_b[b_acc].data, 32'h0123_4567);
      check32("t4_w1_data", acc_b[b_acc+1].data, 32'h89AB_CDEF);
      check32("t4_w2_data", acc_b[b_acc+2].data, 32'h0000_1234);
      check1("t4_w0_tuser", acc_b[b_acc].tuser, 1'b1);
      check1("t4_w1_tuser", acc_b[b_acc+1].tuser, 1'b0);
      check1("t4_w1_tlast", acc_b[b_acc+1].tlast, 1'b0);
      check1("t4_w2_tlast", acc_b[b_acc+2].tlast, 1'b1);
    end

    // Continuous: stop during READ of frame 3
    num_frames = 16'd0; m_tready = 1'b1;
    b_trig = n_trig_a; b_strb = n_strb_a; b_done = n_done_a; b_acc = acc_a.size();
    pulse_start_a();
    for (int i = 0; i < 200; i++) begin
      if (fc_a == 16'd1) break;
      tick();
    end
    check32("t5_fc1", 32'(fc_a), 32'd1);
    pulse_start_a();
    check32("t5_start_ignored", 32'(fc_a), 32'd1);
    check1("t5_busy", busy_a, 1'b1);
    for (int i = 0; i < 200; i++) begin
      if (fc_a == 16'd2 && tvalid_a && tuser_a) break;
      tick();
    end
    check1("t5_frame3_started", tvalid_a && tuser_a, 1'b1);
    tick();
    pulse_stop();
    for (int i = 0; i < 200; i++) begin
      if (done_a) break;
      tick();
    end
    check1("t5_done_seen", done_a, 1'b1);
    tick();
    check32("t5_fc", 32'(fc_a), 32'd3);
    check1("t5_busy_end", busy_a, 1'b0);
    check32("t5_dones", n_done_a - b_done, 32'd1);
    check32("t5_trigs", n_trig_a - b_trig, 32'd3);
    check32("t5_strobes", n_strb_a - b_strb, 32'd24);
    check32("t5_words", acc_a.size() - b_acc, 32'd24);
    check_frame_a("t5f1", b_acc);
    check_frame_a("t5f3", b_acc + 16);

    // Reset mid-frame after two words
    num_frames = 16'd1; b_acc = acc_a.size();
    pulse_start_a();
    for (int i = 0; i < 200; i++) begin
      if (acc_a.size() - b_acc >= 2) break;
      tick();
    end
    rstn = 1'b0;
    #1;
    check32("t6_partial_words", acc_a.size() - b_acc, 32'd2);
    check1("t6_rst_busy", busy_a, 1'b0);
    check1("t6_rst_tvalid", tvalid_a, 1'b0);
    check1("t6_rst_tuser", tuser_a, 1'b0);
    check1("t6_rst_tlast", tlast_a, 1'b0);
    check1("t6_rst_strobe", strb_a, 1'b0);
    check1("t6_rst_trig", trig_a, 1'b0);
    check32("t6_rst_tdata", tdata_a, 32'd0);
    check32("t6_rst_fc", 32'(fc_a), 32'd0);
    tick(); tick();
    rstn = 1'b1;
    repeat (2) tick();
    check1("t6_idle", busy_a, 1'b0);
    b_strb = n_strb_a; b_done = n_done_a; b_acc = acc_a.size();
    pulse_start_a();
    for (int i = 0; i < 200; i++) begin
      if (done_a) break;
      tick();
    end
    check1("t6_done_seen", done_a, 1'b1);
    tick();
    check32("t6_fc", 32'(fc_a), 32'd1);
    check32("t6_strobes", n_strb_a - b_strb, 32'd8);
    check32("t6_dones", n_done_a - b_done, 32'd1);
    check32("t6_words", acc_a.size() - b_acc, 32'd8);
    check_frame_a("t6", b_acc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
